// File: rtl/vram_scheduler.sv
// vram_scheduler
//   Arbitrates one single-port synchronous video RAM between display scanout
//   and a buffered pixel writer. Scanout always wins; queued writes drain in
//   cycles with no fetch (optionally only during vertical blanking).
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   scan_valid/scan_x/scan_y next-cycle scanout request and position
//   vblank                   vertical blanking indicator
//   pixel, pixel_valid       fetched pixel, aligned with the visible cycle
//   wr_valid/wr_ready        writer handshake; wr_addr/wr_data payload
//   mem_addr/mem_we/mem_wdata RAM command (combinational)
//   mem_rdata                RAM read data, one cycle after the address
//   fifo_count               write FIFO occupancy
//   wr_err                   sticky flag: an out-of-range write was dropped
//
// Grant states (re-evaluated every cycle)
//   state    | meaning
//   ST_IDLE  | no RAM access; address holds, write data zero
//   ST_SCAN  | scanout fetch of the next visible pixel
//   ST_DRAIN | pop FIFO head and write it (dropped if out of range)
module vram_scheduler #(
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int DATA_W      = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter bit VBLANK_ONLY = 1'b0,
  localparam int ADDR_W = $clog2(H_VISIBLE*V_VISIBLE),
  localparam int X_W    = $clog2(H_VISIBLE),
  localparam int Y_W    = $clog2(V_VISIBLE),
  localparam int CNT_W  = $clog2(FIFO_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_valid,
  input  logic [X_W-1:0]    scan_x,
  input  logic [Y_W-1:0]    scan_y,
  input  logic              vblank,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              wr_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // One extra bit so the frame size fits even when it is an exact power of two.
  localparam logic [ADDR_W:0] N_PIX = (ADDR_W+1)'(H_VISIBLE*V_VISIBLE);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic              wr_err_q, wr_err_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic [1:0]        state;
  logic              push, pop, drain_ok, head_ok;
  logic [ADDR_W-1:0] head_addr, scan_addr;
  logic [DATA_W-1:0] head_data;

  assign scan_addr = ADDR_W'(scan_y) * ADDR_W'(H_VISIBLE) + ADDR_W'(scan_x);
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_ok   = ({1'b0, head_addr} < N_PIX);
  assign drain_ok  = (count_q != '0) && (!VBLANK_ONLY || vblank);

  // Held in IDLE during reset so the RAM sees no write before the clock runs.
  always_comb begin
    state = ST_IDLE;
    if (!rst)            state = ST_IDLE;
    else if (scan_valid) state = ST_SCAN;
    else if (drain_ok)   state = ST_DRAIN;
  end

  always_comb begin
    mem_addr  = last_addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    pop       = 1'b0;
    case (state)
      ST_SCAN: mem_addr = scan_addr;
      ST_DRAIN: begin
        pop = 1'b1;
        if (head_ok) begin
          mem_addr  = head_addr;
          mem_we    = 1'b1;
          mem_wdata = head_data;
        end
      end
      default: ;
    endcase
  end

  // Ready comes from the registered count, so a full FIFO stays not-ready
  // through the popping cycle and reopens on the next one.
  assign wr_ready = (count_q != FULL_CNT);
  assign push     = wr_valid && wr_ready;

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    pixel_valid_d = (state == ST_SCAN);
    wr_err_d      = wr_err_q | (pop & ~head_ok);
    last_addr_d   = mem_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pixel_valid_q <= 1'b0;
      wr_err_q      <= 1'b0;
      last_addr_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pixel_valid_q <= pixel_valid_d;
      wr_err_q      <= wr_err_d;
      last_addr_q   <= last_addr_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel       = pixel_valid_q ? mem_rdata : '0;
  assign fifo_count  = count_q;
  assign wr_err      = wr_err_q;

endmodule
